// File: rtl/add.sv
// Elementwise vector adder: v2[i] = v0[i] + v1[i] for i = 0..N-1.
// Started by a one-cycle tstart pulse. Each cycle it issues one read to the
// v0/v1 memories and, one cycle later, one write to v2.
// Optional feature: define ADD_DONE_EN to add a one-cycle 'done' pulse that
// fires on the cycle after the final write.
//
// Handshake: none. tstart is a level sampled at posedge and only honoured
// in IDLE. rd_en/addr are presented to synchronous-read memories; their
// rd_data is valid the cycle after. wr_en/addr/data form a single-cycle write.
module add #(
  parameter int N      = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tstart,
  output logic [LANES*ADDR_W-1:0] v0_addr,
  output logic                    v0_rd_en,
  input  logic [DATA_W-1:0]       v0_rd_data,
  output logic [ADDR_W-1:0]       v1_addr,
  output logic                    v1_rd_en,
  input  logic [DATA_W-1:0]       v1_rd_data,
  output logic [ADDR_W-1:0]       v2_addr,
  output logic                    v2_wr_en,
  output logic [2*DATA_W-1:0]     v2_wr_data
`ifdef ADD_DONE_EN
  ,
  output logic                    done
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // Read-side sequencer: walks idx 0..N-1 with rd_en high, then one DRAIN cycle.
  // idx returns to 0 whenever reads stop so idle addresses sit at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      rd_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tstart) begin
            state <= RUN;
            rd_en <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          if (idx == LAST) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

  // Write stage: read enable/address delayed one cycle to line up with rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en   <= rd_en;
      wr_addr <= idx;
    end
  end

`ifdef ADD_DONE_EN
  // Done pulse: registered off the final write so it lands the cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= wr_en && (wr_addr == LAST);
    end
  end
`endif

  assign v0_addr    = {LANES{idx}};
  assign v0_rd_en   = rd_en;
  assign v1_addr    = idx;
  assign v1_rd_en   = rd_en;
  assign v2_addr    = wr_addr;
  assign v2_wr_en   = wr_en;
  // Zero-extended sum; the doubled width keeps the carry.
  assign v2_wr_data = {{DATA_W{1'b0}}, v0_rd_data} + {{DATA_W{1'b0}}, v1_rd_data};

endmodule

// File: tb/tb_add.sv
// Directed testbench for add: reset, full runs, tstart re-pulse, mid-run
// reset with restart, and a carry vector. Memories are modelled as counters
// that increment on each posedge where their read enable is high.
module tb_add;

  localparam int N      = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int LANES  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    tstart = 1'b0;
  logic [LANES*ADDR_W-1:0] v0_addr;
  logic                    v0_rd_en;
  logic [DATA_W-1:0]       v0_rd_data;
  logic [ADDR_W-1:0]       v1_addr;
  logic                    v1_rd_en;
  logic [DATA_W-1:0]       v1_rd_data;
  logic [ADDR_W-1:0]       v2_addr;
  logic                    v2_wr_en;
  logic [2*DATA_W-1:0]     v2_wr_data;
`ifdef ADD_DONE_EN
  logic                    done;
`endif

  int checks = 0;
  int errors = 0;

  add #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .tstart     (tstart),
    .v0_addr    (v0_addr),
    .v0_rd_en   (v0_rd_en),
    .v0_rd_data (v0_rd_data),
    .v1_addr    (v1_addr),
    .v1_rd_en   (v1_rd_en),
    .v1_rd_data (v1_rd_data),
    .v2_addr    (v2_addr),
    .v2_wr_en   (v2_wr_en),
    .v2_wr_data (v2_wr_data)
`ifdef ADD_DONE_EN
    ,
    .done       (done)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Memory models: data counter bumps on each posedge with rd_en high.
  logic [DATA_W-1:0] m0_load, m1_load;
  logic              load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      v0_rd_data <= m0_load;
      v1_rd_data <= m1_load;
    end else begin
      if (v0_rd_en) v0_rd_data <= v0_rd_data + 1'b1;
      if (v1_rd_en) v1_rd_data <= v1_rd_data + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v0_rd_en"}, 64'(v0_rd_en), 64'd0);
    chk({tag, "_v1_rd_en"}, 64'(v1_rd_en), 64'd0);
    chk({tag, "_v2_wr_en"}, 64'(v2_wr_en), 64'd0);
    chk({tag, "_v0_addr"},  64'(v0_addr),  64'd0);
    chk({tag, "_v1_addr"},  64'(v1_addr),  64'd0);
    chk({tag, "_v2_addr"},  64'(v2_addr),  64'd0);
  endtask

  // Load memory start values (takes one idle cycle), pulse tstart, then
  // check every read and write. Returns early if abort_at is reached.
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input int repulse_at, input int abort_at);
    logic [LANES*ADDR_W-1:0] lanes;
    logic [63:0]             exp;
    logic [31:0]             ea, eb;
    m0_load = a;
    m1_load = b;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    tstart  = 1'b1;
    tick();
    tstart  = 1'b0;
    chk("start_wr_en_low", 64'(v2_wr_en), 64'd0);
    for (int i = 0; i < N; i++) begin
      for (int l = 0; l < LANES; l++) lanes[l*ADDR_W +: ADDR_W] = ADDR_W'(i);
      chk("rd_en0", 64'(v0_rd_en), 64'd1);
      chk("rd_en1", 64'(v1_rd_en), 64'd1);
      chk("v0_addr", 64'(v0_addr), 64'(lanes));
      chk("v1_addr", 64'(v1_addr), 64'(i));
      if (i == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");
        return;
      end
      if (i == repulse_at) tstart = 1'b1;
      tick();
      tstart = 1'b0;
      ea  = a + 32'd1 + 32'(i);
      eb  = b + 32'd1 + 32'(i);
      exp = {32'd0, ea} + {32'd0, eb};
      chk("wr_en", 64'(v2_wr_en), 64'd1);
      chk("wr_addr", 64'(v2_addr), 64'(i));
      chk("wr_data", v2_wr_data, exp);
    end
    chk("drain_rd_en", 64'(v0_rd_en), 64'd0);
    chk("drain_addr", 64'(v1_addr), 64'd0);
`ifdef ADD_DONE_EN
    chk("done_early", 64'(done), 64'd0);
`endif
    tick();
    chk_idle("post_run");
`ifdef ADD_DONE_EN
    chk("done_pulse", 64'(done), 64'd1);
`endif
    tick();
    chk_idle("post_run2");
`ifdef ADD_DONE_EN
    chk("done_clear", 64'(done), 64'd0);
`endif
  endtask

  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    m0_load = '0;
    m1_load = '0;
    load = 1'b1;
    tick();
    tick();
    chk_idle("reset");
`ifdef ADD_DONE_EN
    chk("reset_done", 64'(done), 64'd0);
`endif
    rst = 1'b0;
    load = 1'b0;
    tick();
    chk_idle("idle");

    // Main vector: writes 107, 109, ..., 361 to addresses 0..127.
    run(32'd5, 32'd100, -1, -1);

    // tstart re-pulsed at i=40: sequence is unaffected.
    run(32'd5, 32'd100, 40, -1);

    // Reset at i=60 aborts; a fresh tstart restarts from address 0.
    run(32'd5, 32'd100, -1, 60);
    run(32'd1000, 32'd2000, -1, -1);

    // Carry: first write is 0xFFFFFFFF + 0xFFFFFFFF = 0x1_FFFFFFFE.
    run(32'hFFFF_FFFE, 32'hFFFF_FFFE, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
